// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the register-file command sequencer.
package regfile_seq_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 3;

  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_MOV  = 2'b01,
    OP_READ = 2'b10,
    OP_SWAP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    RESP = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_seq_if.sv
// Command and response handshakes between the controller and the sequencer.
interface regfile_seq_if #(
  parameter int DW = regfile_seq_pkg::DEF_DW,
  parameter int AW = regfile_seq_pkg::DEF_AW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_seq_load_reg.sv
// Load-enabled register cleared by the asynchronous reset.
module load_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the value until load is asserted; reset clears it to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_seq.sv
// Sequencer that turns MOVI/MOV/READ/SWAP commands into regfile read and
// write cycles and reports the result through a response handshake.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  regfile_seq_if.slave  bus,
  output logic [AW-1:0] rf_writenum,
  output logic [AW-1:0] rf_readnum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out
);

  localparam int CW = 2 + 2 * AW + DW;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic [CW-1:0] cmd_d;
  logic [CW-1:0] cmd_q;
  logic [1:0]    op_raw;
  op_t           op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] tmp_a;
  logic [DW-1:0] tmp_b;
  logic          rsp_load;
  logic [DW-1:0] rsp_d;
  logic [DW-1:0] rsp_q;

  // Commands are only sampled while idle, so later changes on cmd_* are ignored.
  assign accept = (state == IDLE) && bus.cmd_valid;
  assign cmd_d  = {bus.cmd_op, bus.cmd_rd, bus.cmd_rs, bus.cmd_imm};
  assign {op_raw, rd_q, rs_q, imm_q} = cmd_q;
  assign op_q   = op_t'(op_raw);

  load_reg #(.W(CW)) u_cmd_latch (
    .clk(clk), .reset(reset), .load(accept), .d(cmd_d), .q(cmd_q)
  );

  load_reg #(.W(DW)) u_tmp_a (
    .clk(clk), .reset(reset), .load(state == RD1), .d(rf_data_out), .q(tmp_a)
  );

  load_reg #(.W(DW)) u_tmp_b (
    .clk(clk), .reset(reset), .load(state == RD2), .d(rf_data_out), .q(tmp_b)
  );

  // The response is captured on entry to RESP; a READ goes straight from RD1,
  // where tmp_a is not loaded yet, so the live read data is used there.
  assign rsp_load = (state_next == RESP) && (state != RESP);
  assign rsp_d    = (op_q == OP_MOVI) ? imm_q :
                    (state == RD1)    ? rf_data_out : tmp_a;

  load_reg #(.W(DW)) u_rsp (
    .clk(clk), .reset(reset), .load(rsp_load), .d(rsp_d), .q(rsp_q)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing for each command type.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next = (op_t'(bus.cmd_op) == OP_MOVI) ? WR1 : RD1;
        end
      end
      RD1: begin
        case (op_q)
          OP_READ: state_next = RESP;
          OP_SWAP: state_next = RD2;
          default: state_next = WR1;
        endcase
      end
      RD2:     state_next = WR1;
      WR1:     state_next = (op_q == OP_SWAP) ? WR2 : RESP;
      WR2:     state_next = RESP;
      RESP:    state_next = bus.rsp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // Regfile port decode; everything idles at zero outside the active states.
  always_comb begin
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    case (state)
      RD1: rf_readnum = rs_q;
      RD2: rf_readnum = rd_q;
      WR1: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = (op_q == OP_MOVI) ? imm_q : tmp_a;
      end
      WR2: begin
        rf_write    = 1'b1;
        rf_writenum = rs_q;
        rf_data_in  = tmp_b;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Testbench for regfile_seq: a behavioural 8x16 regfile sits on the rf_* pins,
// and results are compared with a command-level reference model.
module tb_regfile_seq;
  import regfile_seq_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rf_writenum;
  logic [AW-1:0] rf_readnum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_data_out;

  logic [DW-1:0] rf_mem [8];
  logic [DW-1:0] model [8];
  int            wr_total = 0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs [14];

  regfile_seq_if #(.DW(DW), .AW(AW)) bus ();

  regfile_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .rf_writenum(rf_writenum),
    .rf_readnum(rf_readnum),
    .rf_write(rf_write),
    .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read, never reset.
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  end
  assign rf_data_out = rf_mem[rf_readnum];

  // Count cycles with the write strobe high.
  always @(negedge clk) begin
    if (rf_write) wr_total <= wr_total + 1;
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                              input logic [15:0] imm, input logic [15:0] d, input int lat, input int wr);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm;
    v.exp_data = d; v.exp_lat = lat; v.exp_wr = wr;
    return v;
  endfunction

  // Command-level model: what each op does to the register set and returns.
  function automatic void model_step(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [15:0] imm, output logic [15:0] d, output int lat, output int wr);
    logic [15:0] a;
    logic [15:0] b;
    case (op)
      2'b00: begin model[rd] = imm; d = imm; lat = 2; wr = 1; end
      2'b01: begin d = model[rs]; model[rd] = d; lat = 3; wr = 1; end
      2'b10: begin d = model[rs]; lat = 2; wr = 0; end
      default: begin
        a = model[rs]; b = model[rd];
        model[rd] = a; model[rs] = b;
        d = a; lat = 5; wr = 2;
      end
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issue one command, then measure latency, write cycles and response data.
  task automatic apply_stimulus(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                input logic [15:0] imm, output logic [15:0] got_data,
                                output int got_lat, output int got_wr);
    int base;
    @(negedge clk);
    check_output("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs    = rs;
    bus.cmd_imm   = imm;
    bus.rsp_ready = 1'b1;
    base = wr_total;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_rd    = 3'($urandom);
    bus.cmd_rs    = 3'($urandom);
    bus.cmd_imm   = 16'($urandom);
    got_lat = 1;
    while (!bus.rsp_valid && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_data = bus.rsp_data;
    got_wr   = wr_total - base;
    @(posedge clk); #1;
    check_output("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_checked(input string tag, input logic [1:0] op, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [15:0] imm);
    logic [15:0] gd, ed;
    int gl, gw, el, ew;
    apply_stimulus(op, rd, rs, imm, gd, gl, gw);
    model_step(op, rd, rs, imm, ed, el, ew);
    check_output({tag, "_data"}, 32'(gd), 32'(ed));
    check_output({tag, "_lat"}, 32'(gl), 32'(el));
    check_output({tag, "_wr"}, 32'(gw), 32'(ew));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] gd, md;
    int gl, gw, ml, mw, n;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_rd    = '0;
    bus.cmd_rs    = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b0;

    vecs[0]  = mk(OP_MOVI, 3'd3, 3'd0, 16'h00A5, 16'h00A5, 2, 1);
    vecs[1]  = mk(OP_READ, 3'd0, 3'd3, 16'h0000, 16'h00A5, 2, 0);
    vecs[2]  = mk(OP_MOVI, 3'd1, 3'd0, 16'h1234, 16'h1234, 2, 1);
    vecs[3]  = mk(OP_MOV,  3'd6, 3'd1, 16'h0000, 16'h1234, 3, 1);
    vecs[4]  = mk(OP_READ, 3'd0, 3'd6, 16'h0000, 16'h1234, 2, 0);
    vecs[5]  = mk(OP_MOVI, 3'd2, 3'd0, 16'hBEEF, 16'hBEEF, 2, 1);
    vecs[6]  = mk(OP_MOVI, 3'd5, 3'd0, 16'h0042, 16'h0042, 2, 1);
    vecs[7]  = mk(OP_SWAP, 3'd2, 3'd5, 16'h0000, 16'h0042, 5, 2);
    vecs[8]  = mk(OP_READ, 3'd0, 3'd2, 16'h0000, 16'h0042, 2, 0);
    vecs[9]  = mk(OP_READ, 3'd0, 3'd5, 16'h0000, 16'hBEEF, 2, 0);
    vecs[10] = mk(OP_MOVI, 3'd4, 3'd0, 16'h7777, 16'h7777, 2, 1);
    vecs[11] = mk(OP_SWAP, 3'd4, 3'd4, 16'h0000, 16'h7777, 5, 2);
    vecs[12] = mk(OP_READ, 3'd0, 3'd4, 16'h0000, 16'h7777, 2, 0);
    vecs[13] = mk(OP_MOV,  3'd1, 3'd1, 16'h0000, 16'h1234, 3, 1);

    // Reset state.
    @(negedge clk);
    check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_rf_write", 32'(rf_write), 32'd0);
    check_output("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_output("rst_readnum", 32'(rf_readnum), 32'd0);
    reset = 1'b0;

    // Give every register a known value.
    for (int i = 0; i < 8; i++) begin
      run_checked("init", OP_MOVI, 3'(i), 3'd0, 16'($urandom));
    end

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, gd, gl, gw);
      model_step(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, md, ml, mw);
      check_output($sformatf("vec%0d_data", i), 32'(gd), 32'(vecs[i].exp_data));
      check_output($sformatf("vec%0d_lat", i), 32'(gl), 32'(vecs[i].exp_lat));
      check_output($sformatf("vec%0d_wr", i), 32'(gw), 32'(vecs[i].exp_wr));
      check_output($sformatf("vec%0d_model", i), 32'(gd), 32'(md));
    end

    // Backpressure: READ R5 held in RESP while a new command is offered.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_rd    = 3'd0;
    bus.cmd_rs    = 3'd5;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("bp_lat", 32'(n), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_MOVI;
      bus.cmd_rd    = 3'd0;
      bus.cmd_imm   = 16'hDEAD;
      check_output("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_output("bp_rsp_data", 32'(bus.rsp_data), 32'h0000BEEF);
      check_output("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check_output("bp_no_write_r0", 32'(rf_mem[0]), 32'(model[0]));

    // Reset during RD2 of SWAP R2/R5.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SWAP;
    bus.cmd_rd    = 3'd2;
    bus.cmd_rs    = 3'd5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_output("rd2_readnum", 32'(rf_readnum), 32'd2);
    #1 reset = 1'b1;
    #1;
    check_output("rd2_rst_write", 32'(rf_write), 32'd0);
    check_output("rd2_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("rd2_rst_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("rd2_r2_kept", 32'(rf_mem[2]), 32'h00000042);
    check_output("rd2_r5_kept", 32'(rf_mem[5]), 32'h0000BEEF);
    run_checked("post_rst_read2", OP_READ, 3'd0, 3'd2, 16'h0);

    // Reset while the write strobe is high drops the write at once.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MOVI;
    bus.cmd_rd    = 3'd7;
    bus.cmd_imm   = ~model[7];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check_output("wr1_write", 32'(rf_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_output("wr1_rst_write", 32'(rf_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("wr1_r7_kept", 32'(rf_mem[7]), 32'(model[7]));

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      run_checked("rand", 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 16'($urandom));
    end

    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("final_r%0d", i), 32'(rf_mem[i]), 32'(model[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Command sequencer that drives the 8x16 register file's write/read port pins and consumes its combinational read data.
- Accepts one register-transfer command per valid/ready handshake: MOVI, MOV, READ or SWAP.
- Issues the required read and write cycles to the register file, then returns a response over a second valid/ready handshake.
- Sits between the control FSM / test harness and regfile; it is the master of the regfile interface.

Parameters:
- DW, 16, data width; must equal regfile data width.
- AW, 3, register index width; must equal regfile writenum/readnum width.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 MOVI, 01 MOV, 10 READ, 11 SWAP.
- cmd_rd  input  AW  destination register index.
- cmd_rs  input  AW  source register index.
- cmd_imm  input  DW  immediate for MOVI.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  DW  result value (see Behaviour).
- rf_writenum  output  AW  to regfile writenum.
- rf_readnum  output  AW  to regfile readnum.
- rf_write  output  1  to regfile write.
- rf_data_in  output  DW  to regfile data_in.
- rf_data_out  input  DW  from regfile data_out (combinational on rf_readnum).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- States: IDLE, RD1, RD2, WR1, WR2, RESP.
- Reset values: state=IDLE; cmd_ready=1; rsp_valid=0; rf_write=0; rsp_data, tmpA, tmpB, latched op/rd/rs/imm all 0.
- rf_* outputs are decoded combinationally from state and latched fields. Assertion of reset therefore forces rf_write=0 immediately.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/rd/rs/imm, then branch:
  - MOVI -> WR1
  - MOV, READ, SWAP -> RD1
- RD1: rf_readnum=rs; capture rf_data_out into tmpA. Next state: READ -> RESP; MOV -> WR1; SWAP -> RD2.
- RD2 (SWAP only): rf_readnum=rd; capture into tmpB; -> WR1.
- WR1: rf_write=1, rf_writenum=rd, rf_data_in = imm (MOVI) or tmpA (MOV/SWAP). Next: SWAP -> WR2, else -> RESP.
- WR2: rf_write=1, rf_writenum=rs, rf_data_in=tmpB; -> RESP.
- RESP: rsp_valid=1. rsp_data is imm for MOVI and tmpA (old Rs) for MOV/READ/SWAP. On rsp_ready -> IDLE.
- rsp_valid and rsp_data stay stable until accepted. No overlap: a new command is accepted no earlier than the cycle after the response handshake.
- Latency: rsp_valid first high N+1 cycles after the accepting edge.
  - MOVI N=1, READ N=1, MOV N=2, SWAP N=4.
  - Writes land in the regfile at the edge leaving WR1/WR2, so the register contents are updated before rsp_valid rises.
- rf_write=0 in every state except WR1/WR2. rf_readnum=0 when not in RD1/RD2. rf_writenum and rf_data_in are don't-care when rf_write=0; drive 0.
- SWAP with rd==rs: runs full sequence; register value unchanged.
- MOV with rd==rs: rewrites same value.
- cmd_* fields are ignored unless cmd_valid&&cmd_ready. Changes to cmd_* mid-operation have no effect.
- Reset mid-operation aborts and returns to IDLE; any pending write is dropped. A write already committed at an earlier edge remains. Regfile contents are not reset.
- rsp_ready held high in IDLE has no effect.

Decomposition:
- Package regfile_seq_pkg: op_t enum (OP_MOVI=2'b00, OP_MOV=2'b01, OP_READ=2'b10, OP_SWAP=2'b11) and state_t enum.
- DW/AW defaults are package constants.
- One sub-module, load_reg: parameterised load-enabled register with async active-high reset. Used for the command latch, tmpA, tmpB and rsp_data.
- FSM next-state logic and output decode live in regfile_seq.

Test Plan (bench instantiates regfile_seq driving regfile):
- MOVI rd=3 imm=16'h00A5 -> WR1 for one cycle with rf_writenum=3; rsp_valid at accept+2, rsp_data=16'h00A5. Subsequent READ rs=3 returns 16'h00A5 at accept+2.
- MOVI R1=16'h1234, then MOV rd=6 rs=1 -> rsp_data=16'h1234 at accept+3; READ rs=6 -> 16'h1234.
- MOVI R2=16'hBEEF, R5=16'h0042, then SWAP rd=2 rs=5 -> rsp at accept+5 with rsp_data=16'h0042; READ R2=16'h0042, READ R5=16'hBEEF.
- SWAP rd=4 rs=4 with R4=16'h7777 -> R4 still 16'h7777; rf_write high exactly 2 cycles.
- Backpressure: READ R5 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data=16'hBEEF held; cmd_ready=0 throughout; cmd_valid during this time is not accepted.
- Reset asserted during RD2 of SWAP R2/R5 -> rf_write=0 immediately, state IDLE, cmd_ready=1; R2=16'h0042 and R5=16'hBEEF unchanged.
